// File: rtl/m7s_fifo_rd_ctrl.sv
// Read-side controller of the fifo_v2 async FIFO: pointers, flags and RAM read port.
// Define M7S_FIFO_FWFT_EN for first-word-fall-through output; default is standard mode.
module m7s_fifo_rd_ctrl #(
  parameter int AW        = 4,
  parameter int DW        = 8,
  parameter int AEMPTY_TH = 2
) (
  input  logic          rd_clk,
  input  logic          rd_rst_n,
  input  logic          rd_en,
  input  logic [AW:0]   wptr_gray_sync,
  input  logic [DW-1:0] ram_rd_dat,
  output logic          ram_rd_en,
  output logic [AW-1:0] ram_rd_addr,
  output logic [DW-1:0] rd_dat,
  output logic          rd_vld,
  output logic [AW:0]   rptr_gray,
  output logic          empty,
  output logic          aempty,
  output logic [AW:0]   rd_cnt,
  output logic          underflow
);

  localparam logic [AW:0] AE_TH = AEMPTY_TH[AW:0];

  logic [AW:0] rptr_bin;
  logic [AW:0] next_rptr_bin;
  logic [AW:0] next_rptr_gray;
  logic [AW:0] wptr_bin;
  logic [AW:0] next_cnt;
  logic        ram_empty;
  logic        fetch;
  logic        uf_cond;

  // Each binary bit is the XOR of all Gray bits at or above it.
  always_comb begin
    wptr_bin = '0;
    for (int i = 0; i <= AW; i++) wptr_bin[i] = ^(wptr_gray_sync >> i);
  end

  assign next_rptr_bin  = rptr_bin + {{AW{1'b0}}, fetch};
  assign next_rptr_gray = next_rptr_bin ^ (next_rptr_bin >> 1);
  assign next_cnt       = wptr_bin - next_rptr_bin;
  assign ram_rd_en      = fetch;
  assign ram_rd_addr    = rptr_bin[AW-1:0];

  // Flags are computed from the post-fetch pointer so they never run optimistic.
  always_ff @(posedge rd_clk) begin
    if (!rd_rst_n) begin
      rptr_bin  <= '0;
      rptr_gray <= '0;
      ram_empty <= 1'b1;
      rd_cnt    <= '0;
      aempty    <= 1'b1;
      underflow <= 1'b0;
    end else begin
      rptr_bin  <= next_rptr_bin;
      rptr_gray <= next_rptr_gray;
      ram_empty <= (next_rptr_gray == wptr_gray_sync);
      rd_cnt    <= next_cnt;
      aempty    <= (next_cnt <= AE_TH);
      underflow <= uf_cond;
    end
  end

`ifdef M7S_FIFO_FWFT_EN
  typedef enum logic [1:0] {IDLE, RAMQ, HOLD} state_t;

  state_t        state;
  state_t        state_nxt;
  logic [DW-1:0] hold_reg;

  // The hold register keeps the head word once the RAM output is no longer guaranteed.
  always_ff @(posedge rd_clk) begin
    if (!rd_rst_n) begin
      state    <= IDLE;
      hold_reg <= '0;
    end else begin
      state <= state_nxt;
      if (state == RAMQ && !rd_en) hold_reg <= ram_rd_dat;
    end
  end

  always_comb begin
    state_nxt = state;
    fetch     = 1'b0;
    rd_vld    = 1'b0;
    rd_dat    = '0;
    case (state)
      IDLE: begin
        if (!ram_empty) begin
          fetch     = 1'b1;
          state_nxt = RAMQ;
        end
      end
      RAMQ: begin
        rd_vld = 1'b1;
        rd_dat = ram_rd_dat;
        if (rd_en) begin
          if (!ram_empty) fetch = 1'b1;
          else            state_nxt = IDLE;
        end else begin
          state_nxt = HOLD;
        end
      end
      HOLD: begin
        rd_vld = 1'b1;
        rd_dat = hold_reg;
        if (rd_en) begin
          if (!ram_empty) begin
            fetch     = 1'b1;
            state_nxt = RAMQ;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign empty   = ~rd_vld;
  assign uf_cond = rd_en & ~rd_vld;
`else
  logic vld_q;

  always_ff @(posedge rd_clk) begin
    if (!rd_rst_n) vld_q <= 1'b0;
    else           vld_q <= fetch;
  end

  // Data is forced to zero when not valid so reset leaves rd_dat clean.
  assign fetch   = rd_en & ~ram_empty;
  assign uf_cond = rd_en & ram_empty;
  assign empty   = ram_empty;
  assign rd_vld  = vld_q;
  assign rd_dat  = vld_q ? ram_rd_dat : '0;
`endif

endmodule
